// File: rtl/data_ram.sv
// Data-side RAM for the memory stage: registered 1-cycle reads with byte-lane store merging.
// Optional post-reset clear FSM is built when the DRAM_CLEAR_EN macro is defined.
module data_ram #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ram_read_addr,
  output logic [XLEN-1:0] ram_read_data,
  input  logic [1:0]      ram_write_mode,
  input  logic [XLEN-1:0] ram_write_addr,
  input  logic [XLEN-1:0] ram_write_data,
  output logic            ram_ready,
  output logic            ram_misaligned
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;
  localparam logic [1:0] MODE_WORD = 2'b11;

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [XLEN-1:0]  r_read_data;
  logic             r_misaligned;
  logic             w_ready;

  logic [AW-1:0]    w_widx;
  logic [AW-1:0]    w_ridx;
  logic [1:0]       w_woff;
  logic [1:0]       w_roff;
  logic [LANES-1:0] w_be;
  logic [XLEN-1:0]  w_wdata_al;
  logic             w_legal;
  logic             w_wr_req;
  logic             w_we;
  logic             w_mis_c;
  logic [XLEN-1:0]  w_read_word;
  logic [LANES-1:0] w_mem_be;
  logic [AW-1:0]    w_mem_idx;
  logic [XLEN-1:0]  w_mem_wdata;
  logic             w_unused_addr;

  assign w_widx = ram_write_addr[AW+1:2];
  assign w_ridx = ram_read_addr[AW+1:2];
  assign w_woff = ram_write_addr[1:0];
  assign w_roff = ram_read_addr[1:0];

  // Upper address bits alias onto the array and are intentionally ignored.
  assign w_unused_addr = &{1'b0, ram_read_addr[XLEN-1:AW+2], ram_write_addr[XLEN-1:AW+2]};

  // Store decode: lane enables, lane-replicated data and alignment legality.
  always_comb begin
    w_be       = '0;
    w_wdata_al = '0;
    w_legal    = 1'b0;
    case (ram_write_mode)
      MODE_BYTE: begin
        w_be       = LANES'(1) << w_woff;
        w_wdata_al = {LANES{ram_write_data[7:0]}};
        w_legal    = 1'b1;
      end
      MODE_HALF: begin
        w_be       = LANES'(3) << w_woff;
        w_wdata_al = {(LANES/2){ram_write_data[15:0]}};
        w_legal    = ~w_woff[0];
      end
      MODE_WORD: begin
        w_be       = '1;
        w_wdata_al = ram_write_data;
        w_legal    = (w_woff == 2'b00);
      end
      default: ;
    endcase
  end

  assign w_wr_req = (ram_write_mode != MODE_NONE) && w_ready;
  assign w_we     = w_wr_req && w_legal;
  assign w_mis_c  = w_wr_req && !w_legal;

  // Write-first bypass: merge the committing store into a same-index read.
  always_comb begin
    w_read_word = r_mem[w_ridx];
    for (int l = 0; l < int'(LANES); l++) begin
      if (w_we && (w_widx == w_ridx) && w_be[l]) begin
        w_read_word[8*l +: 8] = w_wdata_al[8*l +: 8];
      end
    end
  end

`ifdef DRAM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          r_ready;
  logic          w_clr_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      if (w_clr_we) begin
        r_clr_cnt <= r_clr_cnt + AW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == '1) w_state_nxt = S_IDLE;
      default: ;
    endcase
  end

  always_comb begin
    w_clr_we = 1'b0;
    if (r_state == S_CLEAR) w_clr_we = 1'b1;
  end

  assign w_ready = r_ready;
`else
  assign w_ready = 1'b1;
`endif

  // Single array write port shared by external stores and the clear sweep.
  always_comb begin
    w_mem_be    = w_we ? w_be : '0;
    w_mem_idx   = w_widx;
    w_mem_wdata = w_wdata_al;
`ifdef DRAM_CLEAR_EN
    if (w_clr_we) begin
      w_mem_be    = '1;
      w_mem_idx   = r_clr_cnt;
      w_mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < int'(LANES); l++) begin
      if (w_mem_be[l]) begin
        r_mem[w_mem_idx][8*l +: 8] <= w_mem_wdata[8*l +: 8];
      end
    end
  end

  // Read result is right-aligned by the lane offset; held at zero until ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data  <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_mis_c;
      r_read_data  <= w_ready ? (w_read_word >> {w_roff, 3'b000}) : '0;
    end
  end

  assign ram_read_data  = r_read_data;
  assign ram_misaligned = r_misaligned;
  assign ram_ready      = w_ready;

endmodule

// File: tb/tb_data_ram.sv
// Directed vector bench for data_ram (DEPTH_LOG2=4); covers the clear FSM when DRAM_CLEAR_EN is defined.
module tb_data_ram;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] M0 = 2'b00;
  localparam logic [1:0] MB = 2'b01;
  localparam logic [1:0] MH = 2'b10;
  localparam logic [1:0] MW = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] ram_read_addr;
  logic [XLEN-1:0] ram_read_data;
  logic [1:0]      ram_write_mode;
  logic [XLEN-1:0] ram_write_addr;
  logic [XLEN-1:0] ram_write_data;
  logic            ram_ready;
  logic            ram_misaligned;

  always #5 clk = ~clk;

  data_ram #(.XLEN(XLEN), .DEPTH_LOG2(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data),
    .ram_write_mode (ram_write_mode),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_ready      (ram_ready),
    .ram_misaligned (ram_misaligned)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    ram_write_mode = v.mode;
    ram_write_addr = v.waddr;
    ram_write_data = v.wdata;
    ram_read_addr  = v.raddr;
    @(posedge clk);
    #1;
    if (v.chk_rd) chk($sformatf("vec%0d rdata", idx), ram_read_data, v.exp_rd);
    chk($sformatf("vec%0d misaligned", idx), {31'b0, ram_misaligned}, {31'b0, v.exp_mis});
  endtask

`ifdef DRAM_CLEAR_EN
  // Counts cycles until ready rises; read data must stay zero meanwhile.
  task automatic wait_clear();
    int cnt;
    bit nonzero;
    cnt = 0;
    nonzero = 1'b0;
    while (!ram_ready && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (!ram_ready && ram_read_data != 32'h0) nonzero = 1'b1;
    end
    chk("clear_cycles", 32'(cnt), 32'd16);
    chk("rdata_held_during_clear", {31'b0, nonzero}, 32'd0);
    ram_write_mode = M0;
  endtask
`endif

  initial begin
    vecs[0]  = '{MW, 32'h00, 32'h0000_0000, 32'h00, 1'b1, 32'h0000_0000, 1'b0};
    vecs[1]  = '{MW, 32'h10, 32'hDEAD_BEEF, 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{M0, 32'h00, 32'h0000_0000, 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{MB, 32'h13, 32'h0000_00AA, 32'h00, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4]  = '{M0, 32'h00, 32'h0000_0000, 32'h13, 1'b1, 32'h0000_00AA, 1'b0};
    vecs[5]  = '{M0, 32'h00, 32'h0000_0000, 32'h10, 1'b1, 32'hAAAD_BEEF, 1'b0};
    vecs[6]  = '{M0, 32'h00, 32'h0000_0000, 32'h11, 1'b1, 32'h00AA_ADBE, 1'b0};
    vecs[7]  = '{M0, 32'h00, 32'h0000_0000, 32'h12, 1'b1, 32'h0000_AAAD, 1'b0};
    vecs[8]  = '{MH, 32'h11, 32'h0000_1234, 32'h10, 1'b1, 32'hAAAD_BEEF, 1'b1};
    vecs[9]  = '{M0, 32'h00, 32'h0000_0000, 32'h10, 1'b1, 32'hAAAD_BEEF, 1'b0};
    vecs[10] = '{MH, 32'h12, 32'h0000_5678, 32'h10, 1'b1, 32'h5678_BEEF, 1'b0};
    vecs[11] = '{MW, 32'h20, 32'h0102_0304, 32'h22, 1'b1, 32'h0000_0102, 1'b0};
    vecs[12] = '{MW, 32'h21, 32'hFFFF_FFFF, 32'h20, 1'b1, 32'h0102_0304, 1'b1};
    vecs[13] = '{MB, 32'h21, 32'hFFFF_FF77, 32'h20, 1'b1, 32'h0102_7704, 1'b0};
    vecs[14] = '{MH, 32'h20, 32'hABCD_9999, 32'h20, 1'b1, 32'h0102_9999, 1'b0};
    vecs[15] = '{MW, 32'h60, 32'hCAFE_F00D, 32'h20, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[16] = '{MW, 32'h10, 32'h1111_1111, 32'h20, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[17] = '{M0, 32'h00, 32'h0000_0000, 32'h50, 1'b1, 32'h1111_1111, 1'b0};
    vecs[18] = '{MB, 32'h12, 32'h0000_005A, 32'h12, 1'b1, 32'h0000_115A, 1'b0};
    vecs[19] = '{MW, 32'h12, 32'h0000_0000, 32'h10, 1'b1, 32'h115A_1111, 1'b1};
    vecs[20] = '{MH, 32'h13, 32'h0000_0000, 32'h13, 1'b1, 32'h0000_0011, 1'b1};
    vecs[21] = '{M0, 32'h13, 32'h0000_FFFF, 32'h10, 1'b1, 32'h115A_1111, 1'b0};

    rst            = 1'b0;
    ram_read_addr  = '0;
    ram_write_mode = M0;
    ram_write_addr = '0;
    ram_write_data = '0;

    #2;
    chk("reset rdata", ram_read_data, 32'h0);
    chk("reset misaligned", {31'b0, ram_misaligned}, 32'd0);
`ifdef DRAM_CLEAR_EN
    chk("reset ready", {31'b0, ram_ready}, 32'd0);
`else
    chk("reset ready", {31'b0, ram_ready}, 32'd1);
`endif
    #20 rst = 1'b1;

`ifdef DRAM_CLEAR_EN
    ram_write_mode = MW;
    ram_write_addr = 32'h10;
    ram_write_data = 32'h1234_5678;
    ram_read_addr  = 32'h10;
    wait_clear();
    for (int i = 0; i < 16; i++) begin
      ram_read_addr = 32'(i * 4);
      @(posedge clk);
      #1;
      chk($sformatf("cleared word %0d", i), ram_read_data, 32'h0);
    end
`endif

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Reset in the middle of a read with a misaligned flag pending.
    ram_write_mode = MW;
    ram_write_addr = 32'h11;
    ram_read_addr  = 32'h10;
    @(posedge clk);
    #1;
    chk("pre-reset rdata", ram_read_data, 32'h115A_1111);
    chk("pre-reset misaligned", {31'b0, ram_misaligned}, 32'd1);
    ram_write_mode = M0;
    #2 rst = 1'b0;
    #1;
    chk("async reset rdata", ram_read_data, 32'h0);
    chk("async reset misaligned", {31'b0, ram_misaligned}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("post-release rdata", ram_read_data, 32'h0);
`ifdef DRAM_CLEAR_EN
    wait_clear();
    @(posedge clk);
    #1;
    chk("post-clear read", ram_read_data, 32'h0);
`else
    chk("post-release ready", {31'b0, ram_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("post-release read", ram_read_data, 32'h115A_1111);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
